// File: rtl/shreg_pkg.sv
// Shared mode encodings and FSM state type for the universal shift register.
package shreg_pkg;

    localparam int unsigned MODE_W = 3;

    localparam logic [MODE_W-1:0] MODE_HOLD = 3'b000;
    localparam logic [MODE_W-1:0] MODE_SHR  = 3'b001;
    localparam logic [MODE_W-1:0] MODE_SHL  = 3'b010;
    localparam logic [MODE_W-1:0] MODE_LOAD = 3'b011;
    localparam logic [MODE_W-1:0] MODE_ROR  = 3'b100;
    localparam logic [MODE_W-1:0] MODE_ROL  = 3'b101;
    localparam logic [MODE_W-1:0] MODE_CLR  = 3'b110;
    localparam logic [MODE_W-1:0] MODE_SER  = 3'b111;

    typedef enum logic {
        IDLE = 1'b0,
        SER  = 1'b1
    } shreg_state_t;

endpackage

// File: rtl/univ_shift_reg_if.sv
// Control/data bundle for univ_shift_reg; q_par exists only with SHREG_PARITY_EN.
interface univ_shift_reg_if
    import shreg_pkg::*;
#(
    parameter int unsigned WIDTH = 8
);
    logic              en;
    logic [MODE_W-1:0] mode;
    logic [WIDTH-1:0]  d;
    logic              ser_in_r;
    logic              ser_in_l;
    logic [WIDTH-1:0]  q;
    logic              ser_out_r;
    logic              ser_out_l;
    logic              busy;
    logic              done;
`ifdef SHREG_PARITY_EN
    logic              q_par;
`endif

    modport master (
        output en, mode, d, ser_in_r, ser_in_l,
`ifdef SHREG_PARITY_EN
        input  q_par,
`endif
        input  q, ser_out_r, ser_out_l, busy, done
    );

    modport slave (
        input  en, mode, d, ser_in_r, ser_in_l,
`ifdef SHREG_PARITY_EN
        output q_par,
`endif
        output q, ser_out_r, ser_out_l, busy, done
    );

endinterface

// File: rtl/shreg_bitcnt.sv
// Loadable falling-edge down-counter with enable, clear and zero flag; never wraps below 0.
module shreg_bitcnt #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         i_en,
    input  logic         i_clr,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_dec,
    output logic [W-1:0] o_cnt,
    output logic         o_zero_c
);

    logic [W-1:0] r_cnt;

    always_ff @(negedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cnt <= '0;
        end else if (i_en) begin
            if (i_clr) begin
                r_cnt <= '0;
            end else if (i_load) begin
                r_cnt <= i_load_val;
            end else if (i_dec && (r_cnt != '0)) begin
                r_cnt <= r_cnt - W'(1);
            end
        end
    end

    assign o_cnt    = r_cnt;
    assign o_zero_c = (r_cnt == '0);

endmodule

// File: rtl/univ_shift_reg.sv
// WIDTH-bit universal register (hold/shift/rotate/load/clear) with LSB-first auto-serialize.
// Optional registered even parity of q when SHREG_PARITY_EN is defined.
module univ_shift_reg
    import shreg_pkg::*;
#(
    parameter int unsigned      WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rstn,
    univ_shift_reg_if.slave  bus
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    shreg_state_t     r_state;
    logic [WIDTH-1:0] r_q;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] w_q_nxt;
    logic [CNT_W-1:0] w_cnt;
    logic             w_cnt_zero;
    logic             w_start;
    logic             w_last;

    assign w_start = (r_state == IDLE) && (bus.mode == MODE_SER);
    assign w_last  = (r_state == SER) && (w_cnt == CNT_W'(1));

    // Counter is parked at zero in IDLE; skip the clear write when already there.
    shreg_bitcnt #(
        .W (CNT_W)
    ) u_bitcnt (
        .clk        (clk),
        .rstn       (rstn),
        .i_en       (bus.en),
        .i_clr      ((r_state == IDLE) && !w_start && !w_cnt_zero),
        .i_load     (w_start),
        .i_load_val (CNT_W'(WIDTH - 1)),
        .i_dec      (r_state == SER),
        .o_cnt      (w_cnt),
        .o_zero_c   (w_cnt_zero)
    );

    // Next register value; mode is ignored while serializing.
    always_comb begin
        w_q_nxt = r_q;
        if (bus.en) begin
            if (r_state == SER) begin
                w_q_nxt = {bus.ser_in_r, r_q[WIDTH-1:1]};
            end else begin
                case (bus.mode)
                    MODE_HOLD: w_q_nxt = r_q;
                    MODE_SHR:  w_q_nxt = {bus.ser_in_r, r_q[WIDTH-1:1]};
                    MODE_SHL:  w_q_nxt = {r_q[WIDTH-2:0], bus.ser_in_l};
                    MODE_LOAD: w_q_nxt = bus.d;
                    MODE_ROR:  w_q_nxt = {r_q[0], r_q[WIDTH-1:1]};
                    MODE_ROL:  w_q_nxt = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
                    MODE_CLR:  w_q_nxt = RST_VAL;
                    MODE_SER:  w_q_nxt = bus.d;
                    default:   w_q_nxt = r_q;
                endcase
            end
        end
    end

    always_ff @(negedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= IDLE;
            r_q     <= RST_VAL;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else if (bus.en) begin
            r_q    <= w_q_nxt;
            r_done <= w_last;
            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_state <= SER;
                        r_busy  <= 1'b1;
                    end
                end
                SER: begin
                    if (w_last) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef SHREG_PARITY_EN
    logic r_par;

    always_ff @(negedge clk or negedge rstn) begin
        if (!rstn) begin
            r_par <= ^RST_VAL;
        end else if (bus.en) begin
            r_par <= ^w_q_nxt;
        end
    end

    assign bus.q_par = r_par;
`endif

    assign bus.q         = r_q;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.ser_out_r = r_q[0];
    assign bus.ser_out_l = r_q[WIDTH-1];

endmodule

// File: doc/univ_shift_reg.md
Name: univ_shift_reg

Overview:
- Parametrised successor to the single-bit reset flop: a WIDTH-bit universal register.
- Modes: hold, shift left/right, rotate, parallel load, synchronous clear.
- Auto-serialize FSM: loads a word and shifts it out LSB-first over WIDTH edges, then reports completion.
- Sits between datapath registers and serial links (SPI/UART-style framing) in the same clocking scheme as the team's flops.

Parameters:
- WIDTH, 8, register width in bits; legal range 2..64.
- RST_VAL, {WIDTH{1'b0}}, value loaded into q on reset and on synchronous clear.

Ports:
- clk  input  1  clock; all state updates on the falling edge, matching the team's flop family.
- rstn  input  1  asynchronous active-low reset.
- en  input  1  update enable; when 0, all state holds, including the FSM and its counter.
- mode  input  3  operation select; encoding is under Behaviour.
- d  input  WIDTH  parallel load data.
- ser_in_r  input  1  serial input for shift right; enters at the MSB.
- ser_in_l  input  1  serial input for shift left; enters at the LSB.
- q  output  WIDTH  register contents.
- ser_out_r  output  1  q[0] (right-shift serial output).
- ser_out_l  output  1  q[WIDTH-1] (left-shift serial output).
- busy  output  1  high while auto-serialize is in progress.
- done  output  1  one-edge pulse when auto-serialize completes.

Behaviour:
- Reset (rstn=0, asynchronous, immediate): q=RST_VAL, busy=0, done=0, state=IDLE, cnt=0. Release takes effect at the next falling edge.
- Mode encoding, applied on each falling edge with en=1 and state=IDLE:
  - 000 hold.
  - 001 shift right: q <= {ser_in_r, q[W-1:1]}.
  - 010 shift left: q <= {q[W-2:0], ser_in_l}.
  - 011 load: q <= d.
  - 100 rotate right.
  - 101 rotate left.
  - 110 clear: q <= RST_VAL.
  - 111 auto-serialize start.
- FSM states: IDLE, SER.
  - IDLE with mode=111: q <= d, cnt <= WIDTH-1, busy <= 1, state -> SER. Bit d[0] appears on ser_out_r immediately after this edge.
  - SER, each enabled edge: q <= {ser_in_r, q[W-1:1]}, cnt <= cnt-1.
  - SER edge with cnt==1: the shift still occurs, state -> IDLE, busy <= 0, done <= 1.
  - Result: busy is high for exactly WIDTH-1 enabled edges, and every bit is presented on ser_out_r for one enabled period.
  - done is cleared on the next enabled edge, so it is high for exactly one enabled period.
- mode is ignored while in SER; a mode=111 request in SER is dropped, not queued.
- en=0 during SER stalls: cnt, q and busy hold, and done holds its value.
- cnt width is $clog2(WIDTH+1); it never wraps below 0, and IDLE forces cnt=0.
- Simultaneous rstn assertion and clock edge: reset wins.
- Reset mid-serialize aborts the transfer with no done pulse.
- Outputs are registered (q, busy, done); ser_out_r and ser_out_l are direct wires from q.

Optional Feature:
- Macro SHREG_PARITY_EN.
- Defined: adds output port q_par (1 bit), a registered even parity of the next q value. It updates on the same falling edge as q, resets to ^RST_VAL, and holds when en=0.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package shreg_pkg holds:
  - mode localparams MODE_HOLD, MODE_SHR, MODE_SHL, MODE_LOAD, MODE_ROR, MODE_ROL, MODE_CLR, MODE_SER;
  - FSM state typedef shreg_state_t {IDLE, SER}.
- Sub-module shreg_bitcnt: loadable down-counter with enable, async active-low reset and zero flag, used for cnt.
- All other logic is single-level in univ_shift_reg.

Test Plan (WIDTH=8, RST_VAL=0):
- Load 8'hA5 (mode=011), then shift right 2 edges with ser_in_r=1 -> q=8'hE9; ser_out_r=1.
- q=8'h81, rotate left 1 edge -> 8'h03; rotate right 2 edges from 8'h03 -> 8'hC0.
- Auto-serialize d=8'hB4 with ser_in_r=0:
  - ser_out_r sequence over 8 enabled periods = 0,0,1,0,1,1,0,1;
  - busy high for 7 edges;
  - done high for exactly one enabled period at the end;
  - q=8'h01 at completion.
- Auto-serialize with en=0 held for 3 edges mid-transfer -> q, busy and cnt frozen; completion delayed by exactly 3 edges; bit order unchanged.
- rstn pulled low between edges during SER -> q=0 and busy=0 immediately; no done pulse; next mode=011 with d=8'h5A loads normally.
- With SHREG_PARITY_EN: load 8'h07 -> q_par=1; then clear (mode=110) -> q=0, q_par=0.
